// File: rtl/fetch_block.sv
// Thumb instruction fetch stage: issues sequential halfword reads, keeps a
// small instruction buffer for decode, and handles branch redirects by
// flushing the buffer and discarding responses that are still outstanding.
module fetch_block #(
  parameter int              WORD        = 32,
  parameter int              INSTR_WIDTH = 16,
  parameter int              FIFO_DEPTH  = 2,
  parameter logic [WORD-1:0] RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic                   branch_en_i,
  input  logic [WORD-1:0]        branch_target_i,
  output logic                   imem_req_o,
  output logic [WORD-1:0]        imem_addr_o,
  input  logic                   imem_ready_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic                   instr_valid_o,
  output logic [WORD-1:0]        program_counter_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Fetch PC and the address that the next kept response belongs to.
  // Responses come back in order and addresses are sequential between
  // redirects, so one running address is enough to tag every response.
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [INSTR_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [WORD-1:0]        addr_q [FIFO_DEPTH];

  logic [CW:0] occupancy;
  logic        req_accept;
  logic        rsp_fire;
  logic        push;
  logic        pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Request generation: buffer slots plus outstanding reads bound the issue rate;
  // the request is masked during reset and in a redirect cycle.
  always_comb begin
    occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
    imem_req_o = reset_i && !branch_en_i && (occupancy < (CW+1)'(FIFO_DEPTH));
    imem_addr_o = pc_q;
    req_accept = imem_req_o && imem_ready_i;
    rsp_fire   = imem_rvalid_i && (inflight_q != '0);
  end

  // Next-state logic: redirect flush, PC advance, in-flight/drop accounting, buffer push/pop.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (branch_en_i) begin
      pc_d       = branch_target_i & ~WORD'(1);
      rsp_pc_d   = branch_target_i & ~WORD'(1);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = inflight_q - CW'(rsp_fire);
      drop_d     = inflight_q - CW'(rsp_fire);
    end else begin
      if (req_accept) pc_d = pc_q + WORD'(2);
      inflight_d = inflight_q + CW'(req_accept) - CW'(rsp_fire);
      if (rsp_fire) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else push = 1'b1;
      end
      pop = (count_q != '0) && !stall_i;
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        rsp_pc_d = rsp_pc_q + WORD'(2);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Instruction buffer storage; cleared on reset so decode sees zeros.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= imem_rdata_i;
      addr_q[wr_ptr_q] <= rsp_pc_q;
    end
  end

  // Decode-facing outputs come straight from the buffer head.
  always_comb begin
    instruction_o     = data_q[rd_ptr_q];
    program_counter_o = addr_q[rd_ptr_q];
    instr_valid_o     = (count_q != '0);
  end

endmodule

// File: tb/tb_fetch_block.sv
// Directed bench for fetch_block: a cycle table where the bench plays the
// instruction memory, followed by hand-written wrap and reset sequences.
module tb_fetch_block;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_en_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [15:0] imem_rdata_i = '0;
  logic [15:0] instruction_o;
  logic        instr_valid_o;
  logic [31:0] program_counter_o;

  int total = 0;
  int bad = 0;

  fetch_block dut (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i),
    .branch_en_i(branch_en_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .instruction_o(instruction_o),
    .instr_valid_o(instr_valid_o), .program_counter_o(program_counter_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        ready;
    logic        rvalid;
    logic [15:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] tg,
                              input logic rdy, input logic rv, input logic [15:0] rd,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [15:0] e_instr,
                              input logic [31:0] e_pc);
    vec_t v;
    v.stall = st; v.branch = br; v.target = tg; v.ready = rdy; v.rvalid = rv;
    v.rdata = rd; v.exp_req = e_req; v.exp_addr = e_addr; v.exp_valid = e_valid;
    v.exp_instr = e_instr; v.exp_pc = e_pc;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Instruction and PC are compared only while the head entry is live.
  task automatic checkOutput(input string name, input vec_t v);
    cmp({name, ".req"}, {31'd0, imem_req_o}, {31'd0, v.exp_req});
    cmp({name, ".addr"}, imem_addr_o, v.exp_addr);
    cmp({name, ".valid"}, {31'd0, instr_valid_o}, {31'd0, v.exp_valid});
    if (v.exp_valid) begin
      cmp({name, ".instr"}, {16'd0, instruction_o}, {16'd0, v.exp_instr});
      cmp({name, ".pc"}, program_counter_o, v.exp_pc);
    end
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    @(negedge clk_i);
    stall_i = v.stall; branch_en_i = v.branch; branch_target_i = v.target;
    imem_ready_i = v.ready; imem_rvalid_i = v.rvalid; imem_rdata_i = v.rdata;
    #2;
    checkOutput(name, v);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset values while held in reset, even with memory ready.
    imem_ready_i = 1'b1;
    #2;
    checkOutput("reset", mk(0,0,0,1,0,0, 0,32'h0,0,16'h0,32'h0));
    cmp("reset.instr", {16'd0, instruction_o}, 32'h0);
    cmp("reset.pc", program_counter_o, 32'h0);
    @(posedge clk_i); #2;
    reset_i = 1'b1;

    // stall, branch, target, ready, rvalid, rdata | req, addr, valid, instr, pc
    vecs.push_back(mk(0,0,0,1,0,16'h0,    1,32'h0, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,1,16'h1000, 1,32'h2, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,1,16'h1002, 0,32'h4, 1,16'h1000,32'h0));
    vecs.push_back(mk(0,0,0,1,0,16'h0,    1,32'h4, 1,16'h1002,32'h2));
    vecs.push_back(mk(0,0,0,1,1,16'h1004, 1,32'h6, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,1,16'h1006, 0,32'h8, 1,16'h1004,32'h4));
    vecs.push_back(mk(1,0,0,0,0,16'h0,    1,32'h8, 1,16'h1006,32'h6));
    vecs.push_back(mk(1,0,0,1,0,16'h0,    1,32'h8, 1,16'h1006,32'h6));
    vecs.push_back(mk(1,0,0,1,1,16'h1008, 0,32'hA, 1,16'h1006,32'h6));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,0,0,1,0,16'h0,  0,32'hA, 1,16'h1006,32'h6));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    0,32'hA, 1,16'h1006,32'h6));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    1,32'hA, 1,16'h1008,32'h8));
    vecs.push_back(mk(0,0,0,0,1,16'hBEEF, 1,32'hA, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,0,16'h0,    1,32'hA, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,0,16'h0,    1,32'hC, 0,16'h0,32'h0));
    vecs.push_back(mk(0,1,32'h101,1,0,16'h0, 0,32'hE, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,1,16'h100A, 0,32'h100, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,1,16'h100C, 1,32'h100, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,1,16'h2100, 1,32'h102, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    1,32'h102, 1,16'h2100,32'h100));
    vecs.push_back(mk(0,0,0,1,0,16'h0,    1,32'h102, 0,16'h0,32'h0));
    vecs.push_back(mk(0,1,32'h200,1,1,16'h1102, 0,32'h104, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    1,32'h200, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,0,16'h0,    1,32'h200, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,1,16'h2200, 1,32'h202, 0,16'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    1,32'h202, 1,16'h2200,32'h200));
    vecs.push_back(mk(0,0,0,0,0,16'h0,    1,32'h202, 0,16'h0,32'h0));

    foreach (vecs[i])
      applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Branch under stall flushes a live entry, then the PC wraps past the top.
    applyStimulus("wrap1", mk(0,0,0,1,0,16'h0,    1,32'h202, 0,16'h0,32'h0));
    applyStimulus("wrap2", mk(0,0,0,0,1,16'h1202, 1,32'h204, 0,16'h0,32'h0));
    applyStimulus("wrap3", mk(1,1,32'hFFFF_FFFF,1,0,16'h0, 0,32'h204, 1,16'h1202,32'h202));
    applyStimulus("wrap4", mk(1,0,0,1,0,16'h0,    1,32'hFFFF_FFFE, 0,16'h0,32'h0));
    applyStimulus("wrap5", mk(1,0,0,0,1,16'h3FFE, 1,32'h0, 0,16'h0,32'h0));
    applyStimulus("wrap6", mk(1,0,0,0,0,16'h0,    1,32'h0, 1,16'h3FFE,32'hFFFF_FFFE));
    applyStimulus("wrap7", mk(1,0,0,1,0,16'h0,    1,32'h0, 1,16'h3FFE,32'hFFFF_FFFE));

    // Asynchronous reset with a buffered entry and a read outstanding.
    @(posedge clk_i); #3;
    imem_ready_i = 1'b1;
    reset_i = 1'b0;
    #1;
    checkOutput("async_rst", mk(0,0,0,1,0,0, 0,32'h0,0,16'h0,32'h0));
    cmp("async_rst.instr", {16'd0, instruction_o}, 32'h0);
    cmp("async_rst.pc", program_counter_o, 32'h0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 16'h5A5A;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    stall_i = 1'b0;
    imem_ready_i = 1'b0;
    #2;
    checkOutput("post_rst1", mk(0,0,0,0,1,16'h5A5A, 1,32'h0,0,16'h0,32'h0));
    applyStimulus("post_rst2", mk(0,0,0,0,0,16'h0, 1,32'h0, 0,16'h0,32'h0));
    applyStimulus("post_rst3", mk(0,0,0,1,0,16'h0, 1,32'h0, 0,16'h0,32'h0));
    applyStimulus("post_rst4", mk(0,0,0,0,1,16'h7000, 1,32'h2, 0,16'h0,32'h0));
    applyStimulus("post_rst5", mk(0,0,0,0,0,16'h0, 1,32'h2, 1,16'h7000,32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
